device_n_fifo_arb: RTL and testbench

Parametrised N-channel successor of the two-FIFO device2 buffer stage in the PCIe switching path. It provides one FIFO per ingress channel with per-channel status. A single registered egress port drains the FIFOs under round-robin or fixed-priority arbitration. It adds sticky overflow flags and per-channel fill counts; all logic runs on one clock.

---
 rtl/device_n_fifo_arb_if.sv | 34 +++
 rtl/device_n_fifo_arb.sv | 134 +++++++++++++
 tb/tb_device_n_fifo_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/device_n_fifo_arb_if.sv
// Ingress/egress bundle for device_n_fifo_arb: per-channel write strobes and
// data, egress pop, arbitration mode select, registered egress word and the
// per-channel status vectors (empty, almost_full, sticky overflow, fill).
// master = producer/consumer side, slave = the FIFO/arbiter block.
interface device_n_fifo_arb_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int N_CH   = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*DATA_W-1:0] in;
  logic [N_CH-1:0]        write;
  logic                   pop;
  logic                   rr_mode;
  logic [DATA_W-1:0]      out;
  logic                   out_valid;
  logic [CW-1:0]          out_ch;
  logic [N_CH-1:0]        empty;
  logic [N_CH-1:0]        almost_full;
  logic [N_CH-1:0]        overflow;
  logic [N_CH*(AW+1)-1:0] fill;

  modport master (
    output in, write, pop, rr_mode,
    input  out, out_valid, out_ch, empty, almost_full, overflow, fill
  );

  modport slave (
    input  in, write, pop, rr_mode,
    output out, out_valid, out_ch, empty, almost_full, overflow, fill
  );
endinterface

// File: rtl/device_n_fifo_arb.sv
// N-channel ingress FIFOs drained through one registered egress port (RR or fixed priority).
// Latency: a word written at edge k can appear on out after edge k+1 at the earliest.
// Backpressure: egress holds while out_valid && !pop; a write to a full, undrained FIFO is dropped and flagged.
// Ports: clk, reset (async active-low), bus (slave modport: in/write/pop/rr_mode in;
//        out/out_valid/out_ch/empty/almost_full/overflow/fill out).
module device_n_fifo_arb #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int N_CH   = 2,
  parameter int AF_THR = 3
) (
  input  logic                clk,
  input  logic                reset,
  device_n_fifo_arb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_CNT   = (AW+1)'(AF_THR);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem    [N_CH][DEPTH];
  logic [AW-1:0]     rd_ptr [N_CH];
  logic [AW-1:0]     wr_ptr [N_CH];
  logic [AW:0]       cnt    [N_CH];

  logic [N_CH-1:0]   ovf_q;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic [CW-1:0]     out_ch_q;
  logic [CW-1:0]     rr_ptr;

  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   drain;
  logic [N_CH-1:0]   wr_ok;
  logic [CW-1:0]     gnt;
  logic              gnt_found;
  logic              load;

  // Arbitration uses registered occupancy only, so a word written this edge
  // cannot be granted at the same edge.
  always_comb begin
    elig      = '0;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      elig[c] = (cnt[c] != '0);
    end
    // Round-robin: first look above the last grant, then wrap to the bottom.
    // Fixed priority skips the first pass and simply takes the lowest index.
    if (bus.rr_mode) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!gnt_found && elig[c] && (CW'(c) > rr_ptr)) begin
          gnt_found = 1'b1;
          gnt       = CW'(c);
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (!gnt_found && elig[c]) begin
        gnt_found = 1'b1;
        gnt       = CW'(c);
      end
    end
  end

  assign load = (!out_valid_q || bus.pop) && gnt_found;

  // A full FIFO still accepts a write when its head is leaving this cycle.
  always_comb begin
    drain = '0;
    wr_ok = '0;
    for (int c = 0; c < N_CH; c++) begin
      drain[c] = load && (gnt == CW'(c));
      wr_ok[c] = bus.write[c] && ((cnt[c] != FULL_CNT) || drain[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      ovf_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr      <= CW'(N_CH - 1);
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (wr_ok[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (drain[c]) rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        if (wr_ok[c] && !drain[c])      cnt[c] <= cnt[c] + CNT_ONE;
        else if (!wr_ok[c] && drain[c]) cnt[c] <= cnt[c] - CNT_ONE;
        if (bus.write[c] && !wr_ok[c]) ovf_q[c] <= 1'b1;
      end
      if (load) begin
        out_q       <= mem[gnt][rd_ptr[gnt]];
        out_ch_q    <= gnt;
        out_valid_q <= 1'b1;
        rr_ptr      <= gnt;
      end else if (bus.pop) begin
        // Consumer took the word and nothing is queued: go idle, keep data/channel.
        out_valid_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (wr_ok[c]) mem[c][wr_ptr[c]] <= bus.in[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.fill        = '0;
    bus.empty       = '0;
    bus.almost_full = '0;
    for (int c = 0; c < N_CH; c++) begin
      bus.fill[c*(AW+1) +: (AW+1)] = cnt[c];
      bus.empty[c]                 = (cnt[c] == '0);
      bus.almost_full[c]           = (cnt[c] >= AF_CNT);
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_device_n_fifo_arb.sv
module tb_device_n_fifo_arb;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int N_CH   = 2;
  localparam int AF_THR = 3;
  localparam int AW     = $clog2(DEPTH);
  localparam int DIN_W  = N_CH * DATA_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  device_n_fifo_arb_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH)) bus();

  device_n_fifo_arb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH), .AF_THR(AF_THR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-channel queues plus the egress register contents.
  logic [DATA_W-1:0] mq [N_CH][$];
  logic [DATA_W-1:0] m_out;
  logic              m_vld;
  int                m_ch;
  int                m_rr;
  logic [N_CH-1:0]   m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) mq[c].delete();
    m_out = '0;
    m_vld = 1'b0;
    m_ch  = 0;
    m_rr  = N_CH - 1;
    m_ovf = '0;
  endtask

  // One clock edge of behaviour: pick a source, move the head to the egress
  // register, then offer the writes to whatever room remains.
  task automatic model_step(input logic [N_CH-1:0] wr, input logic [DIN_W-1:0] din,
                            input logic pp, input logic rr);
    int  g;
    bit  found;
    found = 0;
    g     = 0;
    if (rr) begin
      for (int i = 1; i <= N_CH; i++) begin
        if (!found && mq[(m_rr + i) % N_CH].size() > 0) begin
          found = 1;
          g     = (m_rr + i) % N_CH;
        end
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!found && mq[c].size() > 0) begin
          found = 1;
          g     = c;
        end
      end
    end
    if ((!m_vld || pp) && found) begin
      m_out = mq[g].pop_front();
      m_vld = 1'b1;
      m_ch  = g;
      m_rr  = g;
    end else if (pp) begin
      m_vld = 1'b0;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (wr[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(din[c*DATA_W +: DATA_W]);
        else                      m_ovf[c] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("out_valid", 32'(bus.out_valid), 32'(m_vld));
    check("out", 32'(bus.out), 32'(m_out));
    check("out_ch", 32'(bus.out_ch), 32'(m_ch));
    for (int c = 0; c < N_CH; c++) begin
      check("fill", 32'(bus.fill[c*(AW+1) +: (AW+1)]), 32'(mq[c].size()));
      check("empty", 32'(bus.empty[c]), 32'(mq[c].size() == 0));
      check("almost_full", 32'(bus.almost_full[c]), 32'(mq[c].size() >= AF_THR));
      check("overflow", 32'(bus.overflow[c]), 32'(m_ovf[c]));
    end
  endtask

  task automatic cycle(input logic [N_CH-1:0] wr, input logic [DIN_W-1:0] din,
                       input logic pp, input logic rr);
    bus.write   = wr;
    bus.in      = din;
    bus.pop     = pp;
    bus.rr_mode = rr;
    model_step(wr, din, pp, rr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    bus.write = '0;
    bus.in    = '0;
    bus.pop   = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("empty_in_reset", 32'(bus.empty), 32'({N_CH{1'b1}}));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    check("empty_after_rst", 32'(bus.empty), 32'({N_CH{1'b1}}));
    check("ovf_after_rst", 32'(bus.overflow), 32'(0));
  endtask

  logic [DATA_W-1:0] exp_seq [4];
  logic [N_CH-1:0]   rw;
  logic [DIN_W-1:0]  rd;

  initial begin
    reset       = 1'b0;
    bus.write   = '0;
    bus.in      = '0;
    bus.pop     = 1'b0;
    bus.rr_mode = 1'b0;
    model_reset();
    do_reset();

    // Reset mid-traffic: ch0 holds 3 words behind a valid egress word.
    for (int i = 0; i < 4; i++) cycle(2'b01, DIN_W'(8'h30 + i), 1'b0, 1'b0);
    check("pre_rst_fill0", 32'(bus.fill[0 +: AW+1]), 32'(3));
    check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
    do_reset();

    // Overflow: park a ch1 word in the egress register so ch0 fills up.
    cycle(2'b10, {8'h99, 8'h00}, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(2'b01, DIN_W'(8'hA0 + i), 1'b0, 1'b0);
      if (i == 2) check("af_at_3", 32'(bus.almost_full[0]), 32'(1));
    end
    check("fill0_sat", 32'(bus.fill[0 +: AW+1]), 32'(4));
    check("ovf0_set", 32'(bus.overflow[0]), 32'(1));
    for (int i = 0; i < 4; i++) begin
      cycle(2'b00, '0, 1'b1, 1'b0);
      check("ovf_drain", 32'(bus.out), 32'(8'hA0 + i));
    end
    cycle(2'b00, '0, 1'b1, 1'b0);
    check("ovf_idle", 32'(bus.out_valid), 32'(0));

    // Round-robin and fixed priority over the same preload.
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      cycle(2'b11, {8'h20, 8'h10}, 1'b0, m[0]);
      cycle(2'b11, {8'h21, 8'h11}, 1'b0, m[0]);
      check("arb_first", 32'({bus.out, 7'(bus.out_ch)}), 32'({8'h10, 7'd0}));
      if (m == 1) begin
        exp_seq[0] = 8'h20; exp_seq[1] = 8'h11; exp_seq[2] = 8'h21;
      end else begin
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h20; exp_seq[2] = 8'h21;
      end
      for (int i = 0; i < 3; i++) begin
        cycle(2'b00, '0, 1'b1, m[0]);
        check("arb_seq", 32'(bus.out), 32'(exp_seq[i]));
        check("arb_ch", 32'(bus.out_ch), 32'(exp_seq[i][5]));
      end
      cycle(2'b00, '0, 1'b1, m[0]);
      check("arb_done", 32'(bus.out_valid), 32'(0));
    end

    // Full push-pop on ch1.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(2'b10, {8'(8'h61 + i), 8'h00}, 1'b0, 1'b1);
    check("pp_full", 32'(bus.fill[(AW+1) +: AW+1]), 32'(4));
    cycle(2'b10, {8'h55, 8'h00}, 1'b1, 1'b1);
    check("pp_fill", 32'(bus.fill[(AW+1) +: AW+1]), 32'(4));
    check("pp_ovf", 32'(bus.overflow[1]), 32'(0));
    for (int i = 0; i < 4; i++) cycle(2'b00, '0, 1'b1, 1'b1);
    check("pp_last", 32'(bus.out), 32'(8'h55));

    // Latency from an empty system.
    do_reset();
    cycle(2'b01, DIN_W'(8'h3C), 1'b1, 1'b0);
    check("lat_empty0", 32'(bus.empty[0]), 32'(0));
    check("lat_k_valid", 32'(bus.out_valid), 32'(0));
    cycle(2'b00, '0, 1'b1, 1'b0);
    check("lat_k1", 32'({bus.out_valid, bus.out, 7'(bus.out_ch)}), 32'({1'b1, 8'h3C, 7'd0}));
    cycle(2'b00, '0, 1'b1, 1'b0);
    check("lat_k2", 32'(bus.out_valid), 32'(0));

    // Randomised traffic: light pop (FIFOs saturate), then heavy pop.
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 300; n++) begin
        rw = N_CH'($urandom);
        rd = DIN_W'($urandom);
        cycle(rw, rd, ($urandom_range(0, 9) < (ph == 0 ? 3 : 8)), 1'($urandom));
        if (ph == 0 && n == 150) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
